// File: rtl/complex_nr_mult_pipe_if.sv
// complex_nr_mult_pipe_if: operand/result valid-ready bundle for the complex multiplier
interface complex_nr_mult_pipe_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int RES_FIFO_DEPTH = 4
);
    logic                              op_val;
    logic                              op_conj;
    logic [4*DATA_WIDTH-1:0]           op_data;
    logic                              op_ready;
    logic                              res_val;
    logic                              res_ready;
    logic [4*DATA_WIDTH-1:0]           res_data;
    logic                              res_ovf;
    logic [$clog2(RES_FIFO_DEPTH):0]   fifo_level;
    modport master (
        output op_val, op_conj, op_data, res_ready,
        input  op_ready, res_val, res_data, res_ovf, fifo_level
    );
    modport slave (
        input  op_val, op_conj, op_data, res_ready,
        output op_ready, res_val, res_data, res_ovf, fifo_level
    );
endinterface

// File: rtl/complex_nr_mult_pipe.sv
// complex_nr_mult_pipe: A*B or A*conj(B) with NUM_MULT shared multipliers and a FWFT result FIFO
module complex_nr_mult_pipe #(
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_MULT       = 2,
    parameter int RES_FIFO_DEPTH = 4
) (
    input logic                   clk,
    input logic                   rst,
    input logic                   sw_rst,
    complex_nr_mult_pipe_if.slave bus
);
    localparam int DW = DATA_WIDTH;
    localparam int PW = 2 * DW;
    localparam int P  = 4 / NUM_MULT;
    localparam int AW = $clog2(RES_FIFO_DEPTH);
    localparam int LW = AW + 1;

    if (NUM_MULT != 1 && NUM_MULT != 2 && NUM_MULT != 4) begin : g_bad_mult
        $error("NUM_MULT must be 1, 2 or 4");
    end
    if (RES_FIFO_DEPTH < 2 || (RES_FIFO_DEPTH & (RES_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("RES_FIFO_DEPTH must be a power of 2, at least 2");
    end

    typedef enum logic [1:0] {IDLE, MULT, SUM} state_t;

    state_t                state;
    logic signed [DW-1:0]  a_re, a_im, b_re, b_im;
    logic                  conj;
    logic [1:0]            cnt;
    logic signed [PW-1:0]  prod [4];
    logic signed [PW:0]    px [4];
    logic signed [PW-1:0]  mul [NUM_MULT];
    logic [1:0]            idx [NUM_MULT];
    logic signed [PW:0]    re_f, im_f;
    logic                  ovf;
    logic                  live;
    logic                  pend;
    logic [4*DW:0]         pend_d;
    logic [4*DW:0]         mem [RES_FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [LW-1:0]         level;
    logic                  accept, pop;

    // Physical multiplier g handles product slot cnt*NUM_MULT+g: 0 ar*br, 1 ai*bi, 2 ar*bi, 3 ai*br
    for (genvar g = 0; g < NUM_MULT; g++) begin : g_mul
        logic [1:0] k;
        assign k      = 2'(int'(cnt) * NUM_MULT + g);
        assign idx[g] = k;
        assign mul[g] = PW'(k[0] ? a_im : a_re) * PW'((k[1] ^ k[0]) ? b_im : b_re);
    end

    for (genvar g = 0; g < 4; g++) begin : g_ext
        assign px[g] = (PW + 1)'(prod[g]);
    end

    assign re_f = conj ? px[0] + px[1] : px[0] - px[1];
    assign im_f = conj ? px[3] - px[2] : px[2] + px[3];
    assign ovf  = (re_f[PW] ^ re_f[PW-1]) | (im_f[PW] ^ im_f[PW-1]);

    // A result still in the push register counts as occupied so an accepted op always finds a slot
    assign bus.op_ready   = live && state == IDLE && (level + LW'(pend)) < LW'(RES_FIFO_DEPTH);
    assign accept         = bus.op_val & bus.op_ready;
    assign bus.res_val    = level != '0;
    assign pop            = bus.res_val & bus.res_ready;
    assign bus.res_data   = bus.res_val ? mem[rd_ptr][4*DW:1] : '0;
    assign bus.res_ovf    = bus.res_val & mem[rd_ptr][0];
    assign bus.fifo_level = level;

    // Sequencer: capture operands, walk product slots for P cycles, then sum into the push register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            conj  <= 1'b0;
            {a_re, a_im, b_re, b_im} <= '0;
            prod  <= '{default: '0};
            pend  <= 1'b0;
            live  <= 1'b0;
        end else if (sw_rst) begin
            state <= IDLE;
            cnt   <= '0;
            conj  <= 1'b0;
            {a_re, a_im, b_re, b_im} <= '0;
            prod  <= '{default: '0};
            pend  <= 1'b0;
            live  <= 1'b1;
        end else begin
            live <= 1'b1;
            pend <= state == SUM;
            if (state == IDLE && accept) begin
                {a_re, a_im, b_re, b_im} <= bus.op_data;
                conj  <= bus.op_conj;
                cnt   <= '0;
                state <= MULT;
            end else if (state == MULT) begin
                for (int j = 0; j < NUM_MULT; j++) prod[idx[j]] <= mul[j];
                cnt <= cnt + 2'd1;
                if (cnt == 2'(P - 1)) state <= SUM;
            end else if (state == SUM) begin
                state <= IDLE;
            end
        end
    end

    // Push register payload: wrapped real/imag fields plus overflow flag
    always_ff @(posedge clk) begin
        if (state == SUM) pend_d <= {re_f[PW-1:0], im_f[PW-1:0], ovf};
    end

    // FIFO pointers and occupancy; a push and a pop in one cycle cancel in the level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (sw_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(pend);
            rd_ptr <= rd_ptr + AW'(pop);
            level  <= level + LW'(pend) - LW'(pop);
        end
    end

    // FIFO storage; contents are only observable through the valid head
    always_ff @(posedge clk) begin
        if (pend && !sw_rst) mem[wr_ptr] <= pend_d;
    end
endmodule

// File: doc/complex_nr_mult_pipe.md
Name: complex_nr_mult_pipe

Overview:
Parametrised successor of the two-instance complex number multiplier. It computes A*B or A*conj(B) on signed two's-complement operands. The number of physical multipliers is configurable (1, 2 or 4), which trades latency for area. Results are buffered in an output FIFO with a per-result overflow flag, so the block keeps the same op/res valid-ready interface and drops into the existing test environment in place of the fixed-instance multiplier.

Parameters:
DATA_WIDTH, 8, width of each operand component (re/im of A and B).
NUM_MULT, 2, physical multipliers; legal values 1, 2, 4; any other value is an elaboration error.
RES_FIFO_DEPTH, 4, result FIFO entries; power of 2, at least 2.

Ports:
clk  input  1  clock, all state on rising edge.
rst  input  1  asynchronous active-high reset.
sw_rst  input  1  synchronous software clear; overrides all handshakes in the same cycle.
op_val  input  1  operand valid.
op_conj  input  1  sampled with op_data; 1 selects A*conj(B).
op_data  input  4*DATA_WIDTH  operands, packed {a_re, a_im, b_re, b_im}, MSB first.
op_ready  output  1  block can accept an operand.
res_val  output  1  FIFO head valid.
res_ready  input  1  consumer accepts the head.
res_data  output  4*DATA_WIDTH  result, packed {re, im}; each field is 2*DATA_WIDTH, signed.
res_ovf  output  1  overflow flag of the head entry.
fifo_level  output  clog2(RES_FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst asserted, or sw_rst sampled high): FSM goes to IDLE, FIFO is emptied, operand and product registers are cleared.
  Outputs during reset: op_ready=0 while rst is asserted, and 1 from the first edge after rst is released. res_val=0, res_data=0, res_ovf=0, fifo_level=0.
- P = 4/NUM_MULT, the number of multiply cycles.
- FSM has three states: IDLE, MULT, SUM.
- IDLE:
  - op_ready = (fifo_level < RES_FIFO_DEPTH).
  - Accept on op_val & op_ready: register operands and op_conj, clear the cycle counter, go to MULT.
- MULT:
  - Each cycle computes NUM_MULT of the four signed DATA_WIDTH x DATA_WIDTH products, in fixed order ar*br, ai*bi, ar*bi, ai*br, into 2*DATA_WIDTH product registers.
  - Stays P cycles, then goes to SUM.
  - op_ready=0.
- SUM:
  - Results are computed at 2*DATA_WIDTH+1 bits:
    - normal mode: re = ar*br - ai*bi; im = ar*bi + ai*br.
    - conj mode: re = ar*br + ai*bi; im = ai*br - ar*bi.
  - Each field is truncated (wraps) to 2*DATA_WIDTH bits.
  - ovf = 1 if either full-precision value lies outside the signed 2*DATA_WIDTH range.
  - {re, im, ovf} is pushed into the FIFO; the FSM returns to IDLE. op_ready=0 in SUM.
- Latency, with the FIFO empty: res_val rises P+2 cycles after the accept edge (NUM_MULT=1: 6, 2: 4, 4: 3).
  - Throughput is one operation per P+2 cycles.
- Only one operation is in flight at a time. The accept condition guarantees a free FIFO slot at push time.
- FIFO:
  - First-word fall-through: res_val = !empty; res_data and res_ovf show the head.
  - Pop on res_val & res_ready.
  - Push and pop in the same cycle leave fifo_level unchanged. A pop when empty is ignored.
  - Pointers wrap modulo RES_FIFO_DEPTH.
  - Results leave in acceptance order.
- op_data and op_conj are ignored outside the accept cycle. Changing them mid-operation has no effect.
- sw_rst or rst during MULT/SUM aborts the operation: no push occurs, and queued results are discarded.
- op_val held with op_ready low must not be lost: the operand is accepted once op_ready rises.

Test Plan:
1. DATA_WIDTH=8, NUM_MULT=2, op_data=0x030405FE (3+4j)*(5-2j), op_conj=0 -> res_data=0x0017000E (23+14j), res_ovf=0, res_val high 4 cycles after accept.
2. Same operands with op_conj=1 -> res_data=0x0007001A (7+26j), res_ovf=0.
3. op_data=0x80808080 (all -128), op_conj=0 -> re=0, im wraps: res_data=0x00008000, res_ovf=1. With op_conj=1 -> res_data=0x80000000, res_ovf=1.
4. Backpressure, res_ready=0, depth 4:
   - Five ops issued back to back -> four accepted, fifo_level=4, op_ready stays 0, fifth op_val held.
   - One pop -> fifth op accepted next cycle.
   - Results drain in issue order.
5. sw_rst pulse mid-MULT with two results queued -> next cycle res_val=0, fifo_level=0, op_ready=1, no stray result. Async rst asserted between edges -> outputs clear immediately.
6. Rerun scenario 1 with NUM_MULT=1 and NUM_MULT=4 -> identical res_data, latency 6 and 3 cycles.
